// File: rtl/object_tracker.sv
// object_tracker: turns four raw push-buttons into a registered (row, col)
// object centre for the VGA renderer. Buttons are synchronised, and each
// axis runs a tick-paced press / hold / auto-repeat state machine. Steps
// either clamp at the radius-inset bounds or wrap to the opposite bound.
module object_tracker #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int COL_W        = 10,
  parameter int ROW_W        = 9,
  parameter int OBJ_R        = 20,
  parameter int STEP         = 4,
  parameter int TICK_DIV     = 833333,
  parameter int REPEAT_DELAY = 20,
  parameter int WRAP         = 0
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             mov_up,
  input  logic             mov_down,
  input  logic             mov_left,
  input  logic             mov_right,
  output logic [ROW_W-1:0] obj_row,
  output logic [COL_W-1:0] obj_col,
  output logic             moving,
  output logic             edge_hit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } axisState_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // The hold counter only ever reaches REPEAT_DELAY-1.
  localparam int DLY_W  = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  // Button order inside the vectors: [0]=up, [1]=down, [2]=left, [3]=right.
  logic [3:0] btnRaw;
  logic [3:0] syncMeta;
  logic [3:0] syncOut;

  assign btnRaw = {mov_right, mov_left, mov_down, mov_up};

  // Two-flop synchroniser for all four asynchronous buttons.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= 4'b0000;
      syncOut  <= 4'b0000;
    end else begin
      syncMeta <= btnRaw;
      syncOut  <= syncMeta;
    end
  end

  logic [TICK_W-1:0] tickCount;
  logic              tick;

  assign tick = (tickCount == TICK_W'(TICK_DIV - 1));

  // Free-running movement tick divider; tick is high on the terminal count.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      tickCount <= '0;
    end else if (tick) begin
      tickCount <= '0;
    end else begin
      tickCount <= tickCount + TICK_W'(1);
    end
  end

  // Per-axis increase / decrease requests. Axis 0 is the column
  // (right increases), axis 1 is the row (down increases, up decreases).
  logic [1:0] incVec;
  logic [1:0] decVec;
  logic [1:0] hitVec;
  logic [1:0] activeVec;

  assign incVec = {syncOut[1], syncOut[3]};
  assign decVec = {syncOut[0], syncOut[2]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gAxis
      localparam int RES    = (gi == 0) ? H_RES : V_RES;
      localparam int AX_W   = (gi == 0) ? COL_W : ROW_W;
      localparam int MIN_P  = OBJ_R;
      localparam int MAX_P  = RES - 1 - OBJ_R;
      localparam int CENTER = RES / 2;

      axisState_t      stateReg;
      logic [AX_W-1:0] posReg;
      logic [DLY_W-1:0] dlyReg;
      logic            lastUpReg;
      logic            hitReg;
      logic            activeReg;

      logic            dirNz;
      logic            dirUp;
      logic            reversal;
      logic [AX_W:0]   sumUp;
      logic [AX_W-1:0] stepPos;
      logic            stepHit;

      // Both or neither button pressed cancels out to "no direction".
      assign dirNz    = incVec[gi] ^ decVec[gi];
      assign dirUp    = incVec[gi] & ~decVec[gi];
      assign reversal = dirNz && (dirUp != lastUpReg);
      // One bit wider so pos+STEP can never overflow before the bound test.
      assign sumUp    = {1'b0, posReg} + (AX_W+1)'(STEP);

      // Target position and bound flag for a step in the current direction.
      always_comb begin
        stepPos = posReg;
        stepHit = 1'b0;
        if (dirUp) begin
          if (sumUp > (AX_W+1)'(MAX_P)) begin
            stepHit = 1'b1;
            stepPos = (WRAP != 0) ? AX_W'(MIN_P) : AX_W'(MAX_P);
          end else begin
            stepPos = sumUp[AX_W-1:0];
          end
        end else begin
          // pos-STEP<MIN rewritten as pos<MIN+STEP to avoid underflow.
          if ({1'b0, posReg} < (AX_W+1)'(MIN_P + STEP)) begin
            stepHit = 1'b1;
            stepPos = (WRAP != 0) ? AX_W'(MAX_P) : AX_W'(MIN_P);
          end else begin
            stepPos = posReg - AX_W'(STEP);
          end
        end
      end

      // Press / hold / auto-repeat FSM with registered position and flags.
      always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
          stateReg  <= IDLE;
          posReg    <= AX_W'(CENTER);
          dlyReg    <= '0;
          lastUpReg <= 1'b0;
          hitReg    <= 1'b0;
          activeReg <= 1'b0;
        end else begin
          hitReg <= 1'b0;
          case (stateReg)
            IDLE: begin
              if (dirNz) begin
                posReg    <= stepPos;
                hitReg    <= stepHit;
                dlyReg    <= '0;
                lastUpReg <= dirUp;
                stateReg  <= HOLD;
                activeReg <= 1'b1;
              end
            end
            HOLD: begin
              if (!dirNz) begin
                stateReg  <= IDLE;
                activeReg <= 1'b0;
              end else if (reversal) begin
                posReg    <= stepPos;
                hitReg    <= stepHit;
                dlyReg    <= '0;
                lastUpReg <= dirUp;
              end else if (tick) begin
                if (dlyReg == DLY_W'(REPEAT_DELAY - 1)) begin
                  posReg   <= stepPos;
                  hitReg   <= stepHit;
                  stateReg <= REPEAT;
                end else begin
                  dlyReg <= dlyReg + DLY_W'(1);
                end
              end
            end
            REPEAT: begin
              if (!dirNz) begin
                stateReg  <= IDLE;
                activeReg <= 1'b0;
              end else if (reversal) begin
                // A reversal restarts the hold delay in the new direction.
                posReg    <= stepPos;
                hitReg    <= stepHit;
                dlyReg    <= '0;
                lastUpReg <= dirUp;
                stateReg  <= HOLD;
              end else if (tick) begin
                posReg <= stepPos;
                hitReg <= stepHit;
              end
            end
            default: begin
              stateReg  <= IDLE;
              activeReg <= 1'b0;
            end
          endcase
        end
      end

      assign hitVec[gi]    = hitReg;
      assign activeVec[gi] = activeReg;

      if (gi == 0) begin : gColOut
        assign obj_col = posReg;
      end else begin : gRowOut
        assign obj_row = posReg;
      end
    end
  endgenerate

  assign moving   = |activeVec;
  assign edge_hit = |hitVec;

endmodule

// File: tb/tb_object_tracker.sv
// Directed bench for object_tracker with TICK_DIV=4, REPEAT_DELAY=3.
// Two instances: clamp (WRAP=0) and wrap (WRAP=1). Stimulus is driven and
// outputs are sampled on the falling edge; cycle numbers count falling
// edges after the first reset release, so movement ticks land on rising
// edges whose number is a multiple of four.
module tb_object_tracker;

  logic       clk50;
  logic       rst_n;
  logic       movUp, movDown, movLeft, movRight;
  logic       wUp, wDown, wLeft, wRight;
  logic [8:0] objRow, wRow;
  logic [9:0] objCol, wCol;
  logic       moving, wMoving;
  logic       edgeHit, wEdgeHit;

  int checkCount = 0;
  int errorCount = 0;
  int cycleNum   = 0;

  object_tracker #(
    .TICK_DIV(4), .REPEAT_DELAY(3), .WRAP(0)
  ) dut (
    .clk50(clk50), .rst_n(rst_n),
    .mov_up(movUp), .mov_down(movDown), .mov_left(movLeft), .mov_right(movRight),
    .obj_row(objRow), .obj_col(objCol), .moving(moving), .edge_hit(edgeHit)
  );

  object_tracker #(
    .TICK_DIV(4), .REPEAT_DELAY(3), .WRAP(1)
  ) dutW (
    .clk50(clk50), .rst_n(rst_n),
    .mov_up(wUp), .mov_down(wDown), .mov_left(wLeft), .mov_right(wRight),
    .obj_row(wRow), .obj_col(wCol), .moving(wMoving), .edge_hit(wEdgeHit)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkMain(input string tag, input int row, input int col, input int mov, input int hit);
    checkVal({tag, ".row"}, 32'(objRow), 32'(row));
    checkVal({tag, ".col"}, 32'(objCol), 32'(col));
    checkVal({tag, ".moving"}, 32'(moving), 32'(mov));
    checkVal({tag, ".edge_hit"}, 32'(edgeHit), 32'(hit));
  endtask

  task automatic checkWrap(input string tag, input int row, input int col, input int mov, input int hit);
    checkVal({tag, ".wrow"}, 32'(wRow), 32'(row));
    checkVal({tag, ".wcol"}, 32'(wCol), 32'(col));
    checkVal({tag, ".wmoving"}, 32'(wMoving), 32'(mov));
    checkVal({tag, ".wedge_hit"}, 32'(wEdgeHit), 32'(hit));
  endtask

  task automatic stepTo(input int k);
    while (cycleNum < k) begin
      @(negedge clk50);
      cycleNum++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {movUp, movDown, movLeft, movRight} = 4'b0000;
    {wUp, wDown, wLeft, wRight} = 4'b0000;

    @(negedge clk50);
    checkMain("reset", 240, 320, 0, 0);
    checkWrap("reset", 240, 320, 0, 0);
    @(negedge clk50);
    rst_n = 1'b1;
    cycleNum = 0;

    // Idle for 100 cycles: nothing may move.
    for (int k = 1; k <= 100; k++) begin
      stepTo(k);
      checkMain("idle", 240, 320, 0, 0);
    end
    $display("txn idle100: row=%0d col=%0d moving=%0d", objRow, objCol, moving);

    // Two-cycle right pulse: exactly one step, three edges after the rise.
    movRight = 1'b1;
    stepTo(102);
    checkMain("pulse.n2", 240, 320, 0, 0);
    movRight = 1'b0;
    stepTo(103);
    checkMain("pulse.n3", 240, 324, 1, 0);
    stepTo(104);
    checkMain("pulse.n4", 240, 324, 1, 0);
    stepTo(105);
    checkMain("pulse.n5", 240, 324, 0, 0);
    stepTo(110);
    checkMain("pulse.n10", 240, 324, 0, 0);
    $display("txn pulse right: col=%0d", objCol);

    // Down held 40 cycles: immediate step, 3-tick hold, then +4 per tick.
    stepTo(112);
    movDown = 1'b1;
    stepTo(114);
    checkMain("hold.pre", 240, 324, 0, 0);
    stepTo(115);
    checkMain("hold.first", 244, 324, 1, 0);
    stepTo(123);
    checkMain("hold.wait", 244, 324, 1, 0);
    stepTo(124);
    checkMain("hold.rep1", 248, 324, 1, 0);
    stepTo(127);
    checkMain("hold.rep1b", 248, 324, 1, 0);
    stepTo(128);
    checkMain("hold.rep2", 252, 324, 1, 0);
    stepTo(152);
    checkMain("hold.last", 276, 324, 1, 0);
    movDown = 1'b0;
    stepTo(154);
    checkMain("hold.rel2", 276, 324, 1, 0);
    stepTo(155);
    checkMain("hold.rel3", 276, 324, 0, 0);
    stepTo(160);
    checkMain("hold.after", 276, 324, 0, 0);
    $display("txn hold down: row=%0d", objRow);

    // Right held to the column bound: 616 -> clamp 619 with edge_hit each tick.
    movRight = 1'b1;
    stepTo(163);
    checkMain("clamp.first", 276, 328, 1, 0);
    stepTo(172);
    checkMain("clamp.rep1", 276, 332, 1, 0);
    stepTo(455);
    checkMain("clamp.612", 276, 612, 1, 0);
    stepTo(456);
    checkMain("clamp.616", 276, 616, 1, 0);
    stepTo(459);
    checkMain("clamp.616b", 276, 616, 1, 0);
    stepTo(460);
    checkMain("clamp.hit1", 276, 619, 1, 1);
    stepTo(461);
    checkMain("clamp.hit1off", 276, 619, 1, 0);
    stepTo(463);
    checkMain("clamp.gap", 276, 619, 1, 0);
    stepTo(464);
    checkMain("clamp.hit2", 276, 619, 1, 1);
    stepTo(465);
    checkMain("clamp.hit2off", 276, 619, 1, 0);
    movRight = 1'b0;
    stepTo(468);
    checkMain("clamp.rel", 276, 619, 0, 0);
    $display("txn clamp right: col=%0d", objCol);

    // Wrap instance: down to 456, next step wraps to 20; up from 20 wraps to 459.
    stepTo(470);
    wDown = 1'b1;
    stepTo(473);
    checkWrap("wrap.first", 244, 320, 1, 0);
    stepTo(484);
    checkWrap("wrap.rep1", 248, 320, 1, 0);
    stepTo(692);
    checkWrap("wrap.456", 456, 320, 1, 0);
    stepTo(695);
    checkWrap("wrap.456b", 456, 320, 1, 0);
    stepTo(696);
    checkWrap("wrap.down", 20, 320, 1, 1);
    wDown = 1'b0;
    stepTo(697);
    checkWrap("wrap.downoff", 20, 320, 1, 0);
    stepTo(700);
    checkWrap("wrap.rel", 20, 320, 0, 0);
    wUp = 1'b1;
    stepTo(702);
    checkWrap("wrap.uppre", 20, 320, 0, 0);
    stepTo(703);
    checkWrap("wrap.up", 459, 320, 1, 1);
    stepTo(704);
    checkWrap("wrap.upoff", 459, 320, 1, 0);
    wUp = 1'b0;
    stepTo(710);
    checkWrap("wrap.end", 459, 320, 0, 0);
    checkMain("wrap.mainquiet", 276, 619, 0, 0);
    $display("txn wrap: row=%0d", wRow);

    // Left and right together cancel out.
    movLeft  = 1'b1;
    movRight = 1'b1;
    stepTo(715);
    checkMain("both.a", 276, 619, 0, 0);
    stepTo(730);
    checkMain("both.b", 276, 619, 0, 0);
    $display("txn left+right: col=%0d moving=%0d", objCol, moving);

    // Left alone into REPEAT, then asynchronous reset mid-repeat.
    movRight = 1'b0;
    stepTo(732);
    checkMain("left.pre", 276, 619, 0, 0);
    stepTo(733);
    checkMain("left.first", 276, 615, 1, 0);
    stepTo(744);
    checkMain("left.rep1", 276, 611, 1, 0);
    stepTo(748);
    checkMain("left.rep2", 276, 607, 1, 0);
    stepTo(750);
    rst_n = 1'b0;
    #1;
    checkMain("arst", 240, 320, 0, 0);
    checkWrap("arst", 240, 320, 0, 0);
    $display("txn async reset: row=%0d col=%0d", objRow, objCol);

    // Held button after reset release counts as a fresh press.
    stepTo(752);
    rst_n = 1'b1;
    stepTo(754);
    checkMain("fresh.pre", 240, 320, 0, 0);
    stepTo(755);
    checkMain("fresh.first", 240, 316, 1, 0);
    stepTo(763);
    checkMain("fresh.wait", 240, 316, 1, 0);
    stepTo(764);
    checkMain("fresh.rep1", 240, 312, 1, 0);
    movLeft = 1'b0;
    stepTo(770);
    checkMain("fresh.end", 240, 312, 0, 0);
    $display("txn fresh press: col=%0d", objCol);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/object_tracker.md
Name: object_tracker

Overview:
Parametrised successor to the single-circle tracker. Converts four raw push-button inputs into a registered (row, col) object position for the VGA renderer. Adds input synchronisation, a tick-paced auto-repeat state machine per axis, configurable step and bounds, and clamp-or-wrap edge handling. Sits between board buttons and the VGA controller in the top level.

Parameters:
H_RES, 640, visible columns
V_RES, 480, visible rows
COL_W, 10, width of col output
ROW_W, 9, width of row output
OBJ_R, 20, object radius; position kept inside [OBJ_R, RES-1-OBJ_R]
STEP, 4, pixels moved per step (1..OBJ_R)
TICK_DIV, 833333, clk50 cycles per movement tick (60 Hz at 50 MHz), >=2
REPEAT_DELAY, 20, ticks held before auto-repeat starts, >=1
WRAP, 0, 0 = clamp at bounds, 1 = wrap to opposite bound

Ports:
clk50  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous, active-low reset
mov_up  in  1  raw button, active high, asynchronous
mov_down  in  1  raw button, active high, asynchronous
mov_left  in  1  raw button, active high, asynchronous
mov_right  in  1  raw button, active high, asynchronous
obj_row  out  ROW_W  object centre row
obj_col  out  COL_W  object centre column
moving  out  1  high while any axis FSM is not IDLE
edge_hit  out  1  one-cycle pulse when a step was clamped or wrapped

Behaviour:
- Reset (rst_n low, async): obj_col=H_RES/2 (320), obj_row=V_RES/2 (240), moving=0, edge_hit=0, synchronisers 0, tick counter 0, both FSMs IDLE, delay counters 0.
- Each button passes through a 2-flop synchroniser. Axis direction: col d = right-left, row d = down-up (up decreases row). Both or neither pressed -> d=0.
- Tick counter: 0..TICK_DIV-1, free-running; tick=1 for the cycle where count==TICK_DIV-1.
- Per-axis FSM, evaluated every clk50 edge:
  - IDLE: d!=0 -> step now, delay counter=0, go HOLD.
  - HOLD: d==0 -> IDLE. d reversed sign -> step now, counter=0, stay HOLD. Else on tick: counter+1. When counter==REPEAT_DELAY-1 on a tick -> step, go REPEAT.
  - REPEAT: d==0 -> IDLE. Sign reversal -> step, counter=0, go HOLD. Else step on every tick.
- Latency: a button high at rising edge N (meeting setup) gives updated position after edge N+3: sync at N+1, N+2; FSM step registered at N+3.
- Step arithmetic: one-bit-wider intermediate, no overflow. MIN=OBJ_R, MAX=RES-1-OBJ_R.
  - Clamp (WRAP=0): pos+STEP>MAX -> MAX; pos-STEP<MIN -> MIN.
  - Wrap (WRAP=1): pos+STEP>MAX -> MIN; pos-STEP<MIN -> MAX. No modular remainder carried.
  - edge_hit=1 for exactly one cycle whenever either axis clamps or wraps, including a clamp that leaves pos unchanged (already at bound).
- Axes are independent; a diagonal press moves both on the same edge.
- moving = (col FSM != IDLE) | (row FSM != IDLE), registered.
- Release mid-HOLD/REPEAT: FSM to IDLE on the edge after the synchronised release; no further step.
- rst_n asserted mid-operation: immediate return to reset values; after deassertion a held button is treated as a fresh press (one step, then HOLD).

Test Plan:
(bench: TICK_DIV=4, REPEAT_DELAY=3, defaults otherwise)
- Reset release, no buttons -> obj_col=320, obj_row=240, moving=0, edge_hit=0 held for 100 cycles.
- mov_right pulse high for 2 cycles -> obj_col=324 exactly 3 edges after rise; single step only; moving returns to 0.
- mov_down held 40 cycles -> one immediate step (244), next step after 3 ticks, then +4 every 4 cycles; release -> stops within 3 edges.
- Clamp: col driven to 616, mov_right held -> col 619 with edge_hit pulse, later ticks keep 619 and pulse edge_hit each tick.
- Wrap (WRAP=1): row 456, mov_down -> row 20, edge_hit=1 one cycle; mov_up from row 20 -> row 459.
- mov_left and mov_right together -> obj_col unchanged, moving=0; rst_n low during REPEAT -> position snaps to (240,320) asynchronously.
